ddr4_cmd_decoder: RTL and testbench
===================================

# ddr4_cmd_decoder

Front-end stage that feeds `BankGroup`. It samples raw DDR4 command/address pins every `clk`, decodes them into the 19-bit one-hot `commands` vector, and tracks the open row of every bank. For each RD/WR it expands one pin command into a BL-beat burst, presenting the bank address, open row and wrapping column on every beat. It also applies `halt` back-pressure with a one-deep pending slot and flags protocol errors.

## Interface

Parameters:
- `BGWIDTH`, 2: bank-group address bits.
- `BAWIDTH`, 2: bank-address bits per group.
- `ADDRWIDTH`, 17: row address bits.
- `COLWIDTH`, 10: column address bits.
- `BL`, 8: burst length in beats, power of two, at most 2**`COLWIDTH`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `halt` in 1: downstream stall; freezes burst progress and the outputs.
- `cs_n` in 1: chip select, active low.
- `act_n` in 1: activate, active low.
- `ras_n`, `cas_n`, `we_n` in 1 each: double as A16/A15/A14.
- `bg_in` in `BGWIDTH`: bank group.
- `ba_in` in `BAWIDTH`: bank.
- `a_in` in 14: A13..A0. A10 is the auto-precharge / all-banks / ZQ-long bit.
- `commands` out 19: one-hot decoded command, all-zero when idle.
- `bg` out `BGWIDTH`: bank group for the current command.
- `ba` out `BAWIDTH`: bank for the current command.
- `row` out `ADDRWIDTH`: row for the current command.
- `column` out `COLWIDTH`: column for the current beat.
- `beat` out `$clog2(BL)`: beat index within the burst.
- `cmd_err` out 1: one-cycle error pulse.

## Operation

Decode, applied when `cs_n`=0:
- `act_n`=0 gives ACT, with row = {ras_n,cas_n,we_n,a_in[13:0]}.
- Otherwise decode on {ras_n,cas_n,we_n}:
  - 000 gives MRS.
  - 001 gives REF.
  - 010 gives PR; PRA if A10=1.
  - 100 gives WR; WRA if A10=1. Base column = a_in[9:0].
  - 101 gives RD; RDA if A10=1. Base column = a_in[9:0].
  - 110 gives ZQCS; ZQCL if A10=1.
  - 111 gives NOP.
  - 011 is reserved and raises `cmd_err`.

When `cs_n`=1 the pins decode as DES. NOP and DES produce no output.

Open-row table:
- One valid bit and one row per bank, 2**(`BGWIDTH`+`BAWIDTH`) entries.
- ACT to a closed bank opens it.
- PR closes the addressed bank; PRA closes all banks.
- RDA/WRA close their bank after the last beat.
- Errors (`cmd_err` pulses, command dropped, table unchanged):
  - ACT to an open bank.
  - RD/WR/RDA/WRA to a closed bank.
  - PR to a closed bank is *not* an error; it is a legal no-op that is still emitted.

Output FSM has two states, IDLE and BURST:
- IDLE, accepted non-burst command: drive its one-hot bit for exactly one cycle; stay in IDLE.
- IDLE, accepted RD/WR/RDA/WRA: go to BURST with `beat`=0. `row` comes from the table.
- BURST: the same one-hot bit is held for BL cycles. Column = {base[COLWIDTH-1:log2 BL], base[log2 BL-1:0]+beat}, i.e. sequential wrap inside the BL-aligned block.
- After beat BL-1: go to IDLE, or launch the pending command the next cycle.

`halt`:
- While high, all outputs hold their values and `beat` does not advance.
- A one-cycle command still in flight is held, not repeated.

Pending slot (one deep):
- A decoded command arriving while BURST is active or `halt`=1 is stored in the slot.
- If the slot is already full, the new command is dropped and `cmd_err` pulses.
- Table checks are made when a command issues, not when it arrives.

## Timing

- Reset values: `commands`=0, `bg`=0, `ba`=0, `row`=0, `column`=0, `beat`=0, `cmd_err`=0. All banks closed, pending slot empty, FSM in IDLE.
- All outputs are registered. Latency is 1 cycle from pin sample to output.
- `cmd_err` is asserted in the same cycle the erroneous command would have been output.
- Pending handover: the pending command issues in the cycle immediately after the final beat, with no gap.
- Reset in mid-burst: outputs go to zero the next cycle; the pending command and all open rows are lost.
- A PR arriving during a burst to the same bank is queued and issues after the burst.

## Structure

- Package `ddr4_pkg` holds the command bit positions: WRA 0, WR 1, ZQCS 2, ZQCL 3, RDA 4, RD 5, PRA 6, PR 7, REF 8, SRE 9, SRX 10, PDE 11, PDX 12, MRS 13, NOP 14, DES 15, CKEL 16, CKEH 17, ACT 18.
- SRE, SRX, PDE, PDX, CKEL, CKEH, NOP and DES are never driven by this block.
- One sub-module, `ddr4_row_table`: the open-row table with lookup and set/clear ports.

## Test plan

Defaults throughout: BL=8, BGWIDTH=2, BAWIDTH=2.

- **ACT + write burst:** ACT bg0/ba1 with row 0x00005, then WR to ba1 with a_in=0x00D (base column 13). Expect: `commands`=bit18 for 1 cycle; then bit1 held 8 cycles with `row`=5; `column` runs 13,14,15,8,9,10,11,12.
- **Read to closed bank:** RD to ba2 straight after reset. Expect `cmd_err` pulse, `commands` stays 0.
- **Auto-precharge:** ACT ba0 row 7, then RDA col 0 (bit4 held 8 beats). A following RD to ba0 gives `cmd_err`.
- **Halt mid-burst:** during a WR burst, assert `halt` at beat 3 for 4 cycles. Expect beat 3 held 5 cycles total, then beats 4–7; the WR bit stays high 12 cycles in all.
- **Pending overflow:** during a RD burst, send PR then REF. Expect PR queued and emitted (bit7) the cycle after beat 7; REF dropped with `cmd_err`.
- **Reset mid-burst:** assert `reset` at beat 2. Expect all outputs 0 the next cycle; a following RD to the same bank gives `cmd_err`.

Source files
------------

// File: rtl/ddr4_pkg.sv
// rtl/ddr4_pkg.sv - command bit positions, FSM states and decode helpers
package ddr4_pkg;

  localparam int NUM_CMDS = 19;

  typedef enum logic [4:0] {
    CMD_WRA  = 5'd0,
    CMD_WR   = 5'd1,
    CMD_ZQCS = 5'd2,
    CMD_ZQCL = 5'd3,
    CMD_RDA  = 5'd4,
    CMD_RD   = 5'd5,
    CMD_PRA  = 5'd6,
    CMD_PR   = 5'd7,
    CMD_REF  = 5'd8,
    CMD_SRE  = 5'd9,
    CMD_SRX  = 5'd10,
    CMD_PDE  = 5'd11,
    CMD_PDX  = 5'd12,
    CMD_MRS  = 5'd13,
    CMD_NOP  = 5'd14,
    CMD_DES  = 5'd15,
    CMD_CKEL = 5'd16,
    CMD_CKEH = 5'd17,
    CMD_ACT  = 5'd18
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic is_burst(cmd_e c);
    return (c == CMD_WRA) || (c == CMD_WR) || (c == CMD_RDA) || (c == CMD_RD);
  endfunction

  function automatic logic is_autopre(cmd_e c);
    return (c == CMD_WRA) || (c == CMD_RDA);
  endfunction

  function automatic logic [NUM_CMDS-1:0] onehot(cmd_e c);
    logic [NUM_CMDS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ddr4_row_table.sv
// rtl/ddr4_row_table.sv - per-bank open flag and open row with lookup, set and clear ports
module ddr4_row_table #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  localparam int IDXW     = BGWIDTH + BAWIDTH,
  localparam int NBANK    = 1 << IDXW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDXW-1:0]      i_lk_idx,
  output logic                 o_lk_valid,
  output logic [ADDRWIDTH-1:0] o_lk_row,
  input  logic                 i_set_en,
  input  logic [IDXW-1:0]      i_set_idx,
  input  logic [ADDRWIDTH-1:0] i_set_row,
  input  logic                 i_clr0_en,
  input  logic [IDXW-1:0]      i_clr0_idx,
  input  logic                 i_clr1_en,
  input  logic [IDXW-1:0]      i_clr1_idx,
  input  logic                 i_clr_all
);

  logic [NBANK-1:0]     r_valid;
  logic [ADDRWIDTH-1:0] r_rows [NBANK];

  // Open flags: clears apply first so an ACT landing on a bank closing this cycle still opens it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (i_clr_all || (i_clr0_en && i_clr0_idx == IDXW'(i)) ||
            (i_clr1_en && i_clr1_idx == IDXW'(i)))
          r_valid[i] <= 1'b0;
      end
      if (i_set_en)
        r_valid[i_set_idx] <= 1'b1;
    end
  end

  // Row storage is only meaningful while the open flag is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (i_set_en)
      r_rows[i_set_idx] <= i_set_row;
  end

  assign o_lk_valid = r_valid[i_lk_idx];
  assign o_lk_row   = r_rows[i_lk_idx];

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// rtl/ddr4_cmd_decoder.sv - DDR4 pin decoder with burst expansion, halt hold and one-deep pending slot
module ddr4_cmd_decoder
  import ddr4_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  localparam int BEATW    = $clog2(BL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BGWIDTH-1:0]   bg_in,
  input  logic [BAWIDTH-1:0]   ba_in,
  input  logic [13:0]          a_in,
  output logic [NUM_CMDS-1:0]  commands,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic [ADDRWIDTH-1:0] row,
  output logic [COLWIDTH-1:0]  column,
  output logic [BEATW-1:0]     beat,
  output logic                 cmd_err
);

  localparam logic [BEATW-1:0]    LAST_BEAT = BEATW'(BL - 1);
  localparam logic [COLWIDTH-1:0] COL_MASK  = COLWIDTH'(BL - 1);

  // Registered state
  state_e                r_state;
  logic [NUM_CMDS-1:0]   r_commands;
  logic [BGWIDTH-1:0]    r_bg;
  logic [BAWIDTH-1:0]    r_ba;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [COLWIDTH-1:0]   r_column;
  logic [COLWIDTH-1:0]   r_base_col;
  logic [BEATW-1:0]      r_beat;
  logic                  r_err;
  logic                  r_ap;
  logic                  r_pend_valid;
  cmd_e                  r_pend_cmd;
  logic [BGWIDTH-1:0]    r_pend_bg;
  logic [BAWIDTH-1:0]    r_pend_ba;
  logic [16:0]           r_pend_addr;

  // Next-state values
  state_e                w_nxt_state;
  logic [NUM_CMDS-1:0]   w_nxt_commands;
  logic [BGWIDTH-1:0]    w_nxt_bg;
  logic [BAWIDTH-1:0]    w_nxt_ba;
  logic [ADDRWIDTH-1:0]  w_nxt_row;
  logic [COLWIDTH-1:0]   w_nxt_column;
  logic [COLWIDTH-1:0]   w_nxt_base_col;
  logic [BEATW-1:0]      w_nxt_beat;
  logic                  w_nxt_err;
  logic                  w_nxt_ap;
  logic                  w_nxt_pend_valid;
  cmd_e                  w_nxt_pend_cmd;
  logic [BGWIDTH-1:0]    w_nxt_pend_bg;
  logic [BAWIDTH-1:0]    w_nxt_pend_ba;
  logic [16:0]           w_nxt_pend_addr;

  // Pin decode
  logic                  w_dec_valid;
  logic                  w_dec_rsvd;
  cmd_e                  w_dec_cmd;
  logic [16:0]           w_dec_addr;

  // Issue candidate: the pending slot always goes ahead of fresh pins
  cmd_e                  w_c_cmd;
  logic [BGWIDTH-1:0]    w_c_bg;
  logic [BAWIDTH-1:0]    w_c_ba;
  logic [16:0]           w_c_addr;
  logic [COLWIDTH-1:0]   w_c_col;
  logic                  w_c_valid;
  logic                  w_last_beat;
  logic                  w_can_issue;
  logic                  w_issue;
  logic                  w_issue_err;
  logic                  w_issue_ok;
  logic                  w_ap_close;
  logic                  w_bank_open;
  logic                  w_lk_valid;
  logic [ADDRWIDTH-1:0]  w_lk_row;
  logic [BEATW-1:0]      w_beat_inc;
  logic [COLWIDTH-1:0]   w_col_next;

  // Combinational decode of the sampled command pins
  always_comb begin
    w_dec_valid = 1'b0;
    w_dec_rsvd  = 1'b0;
    w_dec_cmd   = CMD_NOP;
    if (!cs_n) begin
      if (!act_n) begin
        w_dec_valid = 1'b1;
        w_dec_cmd   = CMD_ACT;
      end else begin
        w_dec_valid = 1'b1;
        case ({ras_n, cas_n, we_n})
          3'b000:  w_dec_cmd = CMD_MRS;
          3'b001:  w_dec_cmd = CMD_REF;
          3'b010:  w_dec_cmd = a_in[10] ? CMD_PRA  : CMD_PR;
          3'b100:  w_dec_cmd = a_in[10] ? CMD_WRA  : CMD_WR;
          3'b101:  w_dec_cmd = a_in[10] ? CMD_RDA  : CMD_RD;
          3'b110:  w_dec_cmd = a_in[10] ? CMD_ZQCL : CMD_ZQCS;
          3'b011: begin
            w_dec_valid = 1'b0;
            w_dec_rsvd  = 1'b1;
          end
          default: w_dec_valid = 1'b0;
        endcase
      end
    end
  end

  assign w_dec_addr  = {ras_n, cas_n, we_n, a_in};

  assign w_c_valid   = r_pend_valid | w_dec_valid;
  assign w_c_cmd     = r_pend_valid ? r_pend_cmd  : w_dec_cmd;
  assign w_c_bg      = r_pend_valid ? r_pend_bg   : bg_in;
  assign w_c_ba      = r_pend_valid ? r_pend_ba   : ba_in;
  assign w_c_addr    = r_pend_valid ? r_pend_addr : w_dec_addr;
  assign w_c_col     = w_c_addr[COLWIDTH-1:0];

  assign w_last_beat = (r_state == ST_BURST) && (r_beat == LAST_BEAT);
  assign w_can_issue = !halt && ((r_state == ST_IDLE) || w_last_beat);
  assign w_issue     = w_can_issue && w_c_valid;

  // An auto-precharge burst finishing this cycle counts as already closed for the next command
  assign w_ap_close  = w_last_beat && !halt && r_ap;
  assign w_bank_open = w_lk_valid && !(w_ap_close && {r_bg, r_ba} == {w_c_bg, w_c_ba});
  assign w_issue_err = ((w_c_cmd == CMD_ACT) && w_bank_open) ||
                       (is_burst(w_c_cmd) && !w_bank_open);
  assign w_issue_ok  = w_issue && !w_issue_err;

  assign w_beat_inc  = r_beat + BEATW'(1);
  assign w_col_next  = (r_base_col & ~COL_MASK) |
                       ((r_base_col + COLWIDTH'(w_beat_inc)) & COL_MASK);

  ddr4_row_table #(
    .BGWIDTH   (BGWIDTH),
    .BAWIDTH   (BAWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_row_table (
    .clk        (clk),
    .reset      (reset),
    .i_lk_idx   ({w_c_bg, w_c_ba}),
    .o_lk_valid (w_lk_valid),
    .o_lk_row   (w_lk_row),
    .i_set_en   (w_issue_ok && (w_c_cmd == CMD_ACT)),
    .i_set_idx  ({w_c_bg, w_c_ba}),
    .i_set_row  (ADDRWIDTH'(w_c_addr)),
    .i_clr0_en  (w_ap_close),
    .i_clr0_idx ({r_bg, r_ba}),
    .i_clr1_en  (w_issue_ok && (w_c_cmd == CMD_PR)),
    .i_clr1_idx ({w_c_bg, w_c_ba}),
    .i_clr_all  (w_issue_ok && (w_c_cmd == CMD_PRA))
  );

  // Next-state and output logic: slot bookkeeping, then burst advance or command issue
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_commands   = r_commands;
    w_nxt_bg         = r_bg;
    w_nxt_ba         = r_ba;
    w_nxt_row        = r_row;
    w_nxt_column     = r_column;
    w_nxt_base_col   = r_base_col;
    w_nxt_beat       = r_beat;
    w_nxt_ap         = r_ap;
    w_nxt_err        = w_dec_rsvd;
    w_nxt_pend_valid = r_pend_valid;
    w_nxt_pend_cmd   = r_pend_cmd;
    w_nxt_pend_bg    = r_pend_bg;
    w_nxt_pend_ba    = r_pend_ba;
    w_nxt_pend_addr  = r_pend_addr;

    if (w_issue && r_pend_valid)
      w_nxt_pend_valid = 1'b0;

    if (w_dec_valid) begin
      if (r_pend_valid && !w_can_issue) begin
        w_nxt_err = 1'b1;
      end else if (r_pend_valid || !w_can_issue) begin
        w_nxt_pend_valid = 1'b1;
        w_nxt_pend_cmd   = w_dec_cmd;
        w_nxt_pend_bg    = bg_in;
        w_nxt_pend_ba    = ba_in;
        w_nxt_pend_addr  = w_dec_addr;
      end
    end

    if (!halt) begin
      if ((r_state == ST_BURST) && !w_last_beat) begin
        w_nxt_beat   = w_beat_inc;
        w_nxt_column = w_col_next;
      end else begin
        w_nxt_state    = ST_IDLE;
        w_nxt_commands = '0;
        w_nxt_bg       = '0;
        w_nxt_ba       = '0;
        w_nxt_row      = '0;
        w_nxt_column   = '0;
        w_nxt_beat     = '0;
        w_nxt_ap       = 1'b0;
        if (w_issue) begin
          if (w_issue_err) begin
            w_nxt_err = 1'b1;
          end else begin
            w_nxt_commands = onehot(w_c_cmd);
            w_nxt_bg       = w_c_bg;
            w_nxt_ba       = w_c_ba;
            if (is_burst(w_c_cmd)) begin
              w_nxt_state    = ST_BURST;
              w_nxt_row      = w_lk_row;
              w_nxt_column   = w_c_col;
              w_nxt_base_col = w_c_col;
              w_nxt_ap       = is_autopre(w_c_cmd);
            end else if (w_c_cmd == CMD_ACT) begin
              w_nxt_row = ADDRWIDTH'(w_c_addr);
            end
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_commands   <= '0;
      r_bg         <= '0;
      r_ba         <= '0;
      r_row        <= '0;
      r_column     <= '0;
      r_base_col   <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_ap         <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_cmd   <= CMD_NOP;
      r_pend_bg    <= '0;
      r_pend_ba    <= '0;
      r_pend_addr  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_commands   <= w_nxt_commands;
      r_bg         <= w_nxt_bg;
      r_ba         <= w_nxt_ba;
      r_row        <= w_nxt_row;
      r_column     <= w_nxt_column;
      r_base_col   <= w_nxt_base_col;
      r_beat       <= w_nxt_beat;
      r_err        <= w_nxt_err;
      r_ap         <= w_nxt_ap;
      r_pend_valid <= w_nxt_pend_valid;
      r_pend_cmd   <= w_nxt_pend_cmd;
      r_pend_bg    <= w_nxt_pend_bg;
      r_pend_ba    <= w_nxt_pend_ba;
      r_pend_addr  <= w_nxt_pend_addr;
    end
  end

  assign commands = r_commands;
  assign bg       = r_bg;
  assign ba       = r_ba;
  assign row      = r_row;
  assign column   = r_column;
  assign beat     = r_beat;
  assign cmd_err  = r_err;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// tb/tb_ddr4_cmd_decoder.sv - directed self-checking bench for ddr4_cmd_decoder
module tb_ddr4_cmd_decoder;

  localparam logic [18:0] B_WRA  = 19'h00001;
  localparam logic [18:0] B_WR   = 19'h00002;
  localparam logic [18:0] B_ZQCL = 19'h00008;
  localparam logic [18:0] B_RDA  = 19'h00010;
  localparam logic [18:0] B_RD   = 19'h00020;
  localparam logic [18:0] B_PRA  = 19'h00040;
  localparam logic [18:0] B_PR   = 19'h00080;
  localparam logic [18:0] B_REF  = 19'h00100;
  localparam logic [18:0] B_MRS  = 19'h02000;
  localparam logic [18:0] B_ACT  = 19'h40000;

  logic        clk = 1'b0;
  logic        reset, halt, cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0]  bg_in, ba_in;
  logic [13:0] a_in;
  logic [18:0] commands;
  logic [1:0]  bg, ba;
  logic [16:0] row;
  logic [9:0]  column;
  logic [2:0]  beat;
  logic        cmd_err;

  int n_chk  = 0;
  int n_pass = 0;

  ddr4_cmd_decoder dut (
    .clk(clk), .reset(reset), .halt(halt), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg_in(bg_in), .ba_in(ba_in),
    .a_in(a_in), .commands(commands), .bg(bg), .ba(ba), .row(row),
    .column(column), .beat(beat), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic pins(input logic c, input logic ac, input logic [2:0] rcw,
                      input logic [1:0] g, input logic [1:0] b, input logic [13:0] a);
    cs_n = c; act_n = ac; {ras_n, cas_n, we_n} = rcw; bg_in = g; ba_in = b; a_in = a;
  endtask

  task automatic des();
    pins(1'b1, 1'b1, 3'b111, 2'd0, 2'd0, 14'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; halt = 1'b0; des();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; des();
    tick(); tick();
    n_chk++; if (commands !== 19'h0) $display("FAIL reset_commands: got %h exp 0", commands); else n_pass++;
    n_chk++; if (bg !== 2'd0)        $display("FAIL reset_bg: got %0d exp 0", bg); else n_pass++;
    n_chk++; if (ba !== 2'd0)        $display("FAIL reset_ba: got %0d exp 0", ba); else n_pass++;
    n_chk++; if (row !== 17'h0)      $display("FAIL reset_row: got %h exp 0", row); else n_pass++;
    n_chk++; if (column !== 10'd0)   $display("FAIL reset_column: got %0d exp 0", column); else n_pass++;
    n_chk++; if (beat !== 3'd0)      $display("FAIL reset_beat: got %0d exp 0", beat); else n_pass++;
    n_chk++; if (cmd_err !== 1'b0)   $display("FAIL reset_cmd_err: got %b exp 0", cmd_err); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_act_write();
    int exp_col [8] = '{13, 14, 15, 8, 9, 10, 11, 12};
    do_reset();
    pins(1'b0, 1'b0, 3'b000, 2'd0, 2'd1, 14'h0005);
    tick();
    n_chk++; if (commands !== B_ACT) $display("FAIL act_cmd: got %h exp %h", commands, B_ACT); else n_pass++;
    n_chk++; if (row !== 17'h5)      $display("FAIL act_row: got %h exp 5", row); else n_pass++;
    n_chk++; if (ba !== 2'd1)        $display("FAIL act_ba: got %0d exp 1", ba); else n_pass++;
    pins(1'b0, 1'b1, 3'b100, 2'd0, 2'd1, 14'h000D);
    tick();
    des();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_chk++; if (commands !== B_WR) $display("FAIL wr_cmd beat %0d: got %h exp %h", i, commands, B_WR); else n_pass++;
      n_chk++; if (beat !== 3'(i)) $display("FAIL wr_beat: got %0d exp %0d", beat, i); else n_pass++;
      n_chk++; if (column !== 10'(exp_col[i])) $display("FAIL wr_column beat %0d: got %0d exp %0d", i, column, exp_col[i]); else n_pass++;
      n_chk++; if (row !== 17'h5) $display("FAIL wr_row beat %0d: got %h exp 5", i, row); else n_pass++;
    end
    tick();
    n_chk++; if (commands !== 19'h0) $display("FAIL wr_end_idle: got %h exp 0", commands); else n_pass++;
  endtask

  task automatic test_rd_closed();
    do_reset();
    pins(1'b0, 1'b1, 3'b101, 2'd0, 2'd2, 14'h0);
    tick();
    des();
    n_chk++; if (cmd_err !== 1'b1)   $display("FAIL rd_closed_err: got %b exp 1", cmd_err); else n_pass++;
    n_chk++; if (commands !== 19'h0) $display("FAIL rd_closed_cmd: got %h exp 0", commands); else n_pass++;
    tick();
    n_chk++; if (cmd_err !== 1'b0)   $display("FAIL rd_closed_pulse: got %b exp 0", cmd_err); else n_pass++;
  endtask

  task automatic test_autoprecharge();
    do_reset();
    pins(1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 14'h0007);
    tick();
    pins(1'b0, 1'b1, 3'b101, 2'd0, 2'd0, 14'h0400);
    tick();
    des();
    n_chk++; if (row !== 17'h7) $display("FAIL rda_row: got %h exp 7", row); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_chk++; if (commands !== B_RDA) $display("FAIL rda_cmd beat %0d: got %h exp %h", i, commands, B_RDA); else n_pass++;
    end
    tick();
    n_chk++; if (commands !== 19'h0) $display("FAIL rda_end: got %h exp 0", commands); else n_pass++;
    pins(1'b0, 1'b1, 3'b101, 2'd0, 2'd0, 14'h0);
    tick();
    des();
    n_chk++; if (cmd_err !== 1'b1)   $display("FAIL rda_closed_err: got %b exp 1", cmd_err); else n_pass++;
    n_chk++; if (commands !== 19'h0) $display("FAIL rda_closed_cmd: got %h exp 0", commands); else n_pass++;
  endtask

  task automatic test_halt();
    int cnt = 0;
    do_reset();
    pins(1'b0, 1'b0, 3'b100, 2'd1, 2'd3, 14'h2345);
    tick();
    n_chk++; if (row !== 17'h12345) $display("FAIL halt_act_row: got %h exp 12345", row); else n_pass++;
    pins(1'b0, 1'b1, 3'b100, 2'd1, 2'd3, 14'h03F8);
    tick();
    des();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (commands === B_WR) cnt++;
    end
    n_chk++; if (beat !== 3'd3) $display("FAIL halt_pre_beat: got %0d exp 3", beat); else n_pass++;
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commands === B_WR) cnt++;
      n_chk++; if (beat !== 3'd3) $display("FAIL halt_hold_beat %0d: got %0d exp 3", i, beat); else n_pass++;
    end
    halt = 1'b0;
    for (int i = 4; i < 8; i++) begin
      tick();
      if (commands === B_WR) cnt++;
      n_chk++; if (beat !== 3'(i)) $display("FAIL halt_post_beat: got %0d exp %0d", beat, i); else n_pass++;
      if (i == 4) begin
        n_chk++; if (column !== 10'h3FC) $display("FAIL halt_column: got %h exp 3fc", column); else n_pass++;
      end
    end
    tick();
    n_chk++; if (commands !== 19'h0) $display("FAIL halt_end: got %h exp 0", commands); else n_pass++;
    n_chk++; if (cnt != 12) $display("FAIL halt_wr_cycles: got %0d exp 12", cnt); else n_pass++;
  endtask

  task automatic test_pending_overflow();
    do_reset();
    pins(1'b0, 1'b0, 3'b000, 2'd2, 2'd0, 14'h0011);
    tick();
    pins(1'b0, 1'b1, 3'b101, 2'd2, 2'd0, 14'h0020);
    tick();
    pins(1'b0, 1'b1, 3'b010, 2'd2, 2'd0, 14'h0);
    tick();
    n_chk++; if (cmd_err !== 1'b0) $display("FAIL ovf_pr_err: got %b exp 0", cmd_err); else n_pass++;
    pins(1'b0, 1'b1, 3'b001, 2'd0, 2'd0, 14'h0);
    tick();
    des();
    n_chk++; if (cmd_err !== 1'b1) $display("FAIL ovf_ref_err: got %b exp 1", cmd_err); else n_pass++;
    n_chk++; if (commands !== B_RD || beat !== 3'd2) $display("FAIL ovf_burst: got %h/%0d exp %h/2", commands, beat, B_RD); else n_pass++;
    for (int i = 3; i < 8; i++) tick();
    n_chk++; if (commands !== B_RD || beat !== 3'd7) $display("FAIL ovf_last: got %h/%0d exp %h/7", commands, beat, B_RD); else n_pass++;
    tick();
    n_chk++; if (commands !== B_PR) $display("FAIL ovf_pr_issue: got %h exp %h", commands, B_PR); else n_pass++;
    n_chk++; if (bg !== 2'd2 || ba !== 2'd0) $display("FAIL ovf_pr_bank: got %0d/%0d exp 2/0", bg, ba); else n_pass++;
    tick();
    n_chk++; if (commands !== 19'h0) $display("FAIL ovf_pr_once: got %h exp 0", commands); else n_pass++;
    pins(1'b0, 1'b1, 3'b101, 2'd2, 2'd0, 14'h0);
    tick();
    des();
    n_chk++; if (cmd_err !== 1'b1) $display("FAIL ovf_pr_closed: got %b exp 1", cmd_err); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    pins(1'b0, 1'b0, 3'b000, 2'd3, 2'd1, 14'h0009);
    tick();
    pins(1'b0, 1'b1, 3'b101, 2'd3, 2'd1, 14'h0005);
    tick();
    des();
    tick(); tick();
    n_chk++; if (beat !== 3'd2) $display("FAIL rst_mid_beat: got %0d exp 2", beat); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (commands !== 19'h0 || beat !== 3'd0 || column !== 10'd0 || row !== 17'h0 || bg !== 2'd0 || ba !== 2'd0)
      $display("FAIL rst_mid_outputs: got cmd %h beat %0d col %0d row %h", commands, beat, column, row); else n_pass++;
    pins(1'b0, 1'b1, 3'b101, 2'd3, 2'd1, 14'h0);
    tick();
    des();
    n_chk++; if (cmd_err !== 1'b1 || commands !== 19'h0) $display("FAIL rst_mid_rd: got err %b cmd %h exp 1/0", cmd_err, commands); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pins(1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 14'h0);
    tick();
    n_chk++; if (commands !== B_MRS) $display("FAIL b2b_mrs: got %h exp %h", commands, B_MRS); else n_pass++;
    pins(1'b0, 1'b1, 3'b110, 2'd0, 2'd0, 14'h0400);
    tick();
    n_chk++; if (commands !== B_ZQCL) $display("FAIL b2b_zqcl: got %h exp %h", commands, B_ZQCL); else n_pass++;
    pins(1'b0, 1'b1, 3'b001, 2'd0, 2'd0, 14'h0);
    tick();
    n_chk++; if (commands !== B_REF) $display("FAIL b2b_ref: got %h exp %h", commands, B_REF); else n_pass++;
    pins(1'b0, 1'b1, 3'b011, 2'd0, 2'd0, 14'h0);
    tick();
    n_chk++; if (cmd_err !== 1'b1 || commands !== 19'h0) $display("FAIL b2b_rsvd: got err %b cmd %h exp 1/0", cmd_err, commands); else n_pass++;
    pins(1'b0, 1'b1, 3'b010, 2'd0, 2'd0, 14'h0);
    tick();
    n_chk++; if (commands !== B_PR || cmd_err !== 1'b0) $display("FAIL b2b_pr_closed: got cmd %h err %b exp %h/0", commands, cmd_err, B_PR); else n_pass++;
    pins(1'b0, 1'b0, 3'b000, 2'd1, 2'd2, 14'h0003);
    tick();
    n_chk++; if (commands !== B_ACT || row !== 17'h3) $display("FAIL b2b_act: got cmd %h row %h", commands, row); else n_pass++;
    pins(1'b0, 1'b0, 3'b000, 2'd1, 2'd2, 14'h0004);
    tick();
    n_chk++; if (cmd_err !== 1'b1 || commands !== 19'h0) $display("FAIL b2b_act_open: got err %b cmd %h exp 1/0", cmd_err, commands); else n_pass++;
    pins(1'b0, 1'b1, 3'b100, 2'd1, 2'd2, 14'h0402);
    tick();
    n_chk++; if (commands !== B_WRA || row !== 17'h3) $display("FAIL b2b_wra: got cmd %h row %h", commands, row); else n_pass++;
    des();
    for (int i = 1; i < 8; i++) tick();
    pins(1'b0, 1'b1, 3'b010, 2'd0, 2'd0, 14'h0400);
    tick();
    n_chk++; if (commands !== B_PRA) $display("FAIL b2b_pra: got %h exp %h", commands, B_PRA); else n_pass++;
    des();
    tick();
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; des();
    test_reset();
    test_act_write();
    test_rd_closed();
    test_autoprecharge();
    test_halt();
    test_pending_overflow();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
